mem_bus_interconnect: RTL and testbench
=======================================

MEM_BUS_INTERCONNECT -- requirements
Module: mem_bus_interconnect

Interface
REQ-001 SHALL have parameter N, default 2: number of device ports, 1..16.
REQ-002 SHALL have parameter DEV_BASE, default {32'h40000000, 32'h00000000}: packed N x 32 base addresses; slot i at bits [32i+31:32i].
REQ-003 SHALL have parameter DEV_MASK, default {32'hFFFFFF00, 32'hFFFF0000}: packed N x 32 compare masks.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for device ready; 0 disables the timeout.
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF: read data returned on an error response.
REQ-006 SHALL have ports: clk  in  1  clock; nrst  in  1  reset (one clock; reset is asynchronous and active-low).
REQ-007 SHALL have ports: cpu_mem_valid  in  1; cpu_mem_addr  in  32; cpu_mem_wstrb  in  4; cpu_mem_ready  out  1; cpu_mem_rdata  out  32.
REQ-008 SHALL have ports: dev_mem_valid  out  N; dev_mem_ready  in  N; dev_mem_rdata  in  N*32 (slot i at [32i+31:32i]).
REQ-009 SHALL have ports: err_clr  in  1 (clears error status); bus_err  out  1 (sticky error flag); err_timeout  out  1 (1 = timeout, 0 = unmapped); err_addr  out  32 (address of the first error).

Function
REQ-010 SHALL decode device i as matching when (cpu_mem_addr & DEV_MASK[i]) == DEV_BASE[i]; on multiple matches the lowest index wins.
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE and ERR.
REQ-012 IDLE + cpu_mem_valid + match: SHALL latch the index into sel, clear the wait counter, and go to ACCESS.
REQ-013 IDLE + cpu_mem_valid + no match: SHALL go to ERR with err_timeout_cause = 0.
REQ-014 In ACCESS, dev_mem_valid[sel] SHALL be 1 and all other bits 0; in all other states dev_mem_valid SHALL be all zero.
REQ-015 ACCESS + dev_mem_ready[sel]: SHALL register rdata slot sel into cpu_mem_rdata and go to DONE.
REQ-016 In DONE, cpu_mem_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; completion latency is device ready at cycle k -> cpu_mem_ready at cycle k+1.
REQ-017 ACCESS: the wait counter SHALL increment every cycle without ready; when TIMEOUT != 0 and the counter reaches TIMEOUT, the FSM SHALL go to ERR with cause = 1; ready and timeout in the same cycle SHALL resolve as ready (DONE).
REQ-018 The wait counter width SHALL be clog2(TIMEOUT+1) and it SHALL saturate rather than wrap.
REQ-019 In ERR, cpu_mem_ready SHALL be 1 for one cycle with cpu_mem_rdata = ERR_RDATA, then the FSM SHALL return to IDLE.
REQ-020 On entry to ERR while bus_err is 0: SHALL set bus_err = 1, err_addr = cpu_mem_addr, err_timeout = cause; later errors SHALL NOT overwrite these until cleared.
REQ-021 err_clr SHALL clear bus_err, err_timeout and err_addr on the next edge; an error entry in the same cycle wins over err_clr.
REQ-022 cpu_mem_valid dropping in ACCESS (abort): SHALL go to IDLE with no cpu_mem_ready pulse and dev_mem_valid deasserted next cycle.
REQ-023 cpu_mem_addr and cpu_mem_wstrb SHALL pass to devices combinationally (not in ports); sel SHALL stay stable throughout ACCESS.
REQ-024 A new cpu_mem_valid seen in IDLE directly after DONE or ERR SHALL start a new transaction with no extra idle cycle.

Reset
REQ-025 On nrst low, asynchronously: FSM = IDLE, sel = 0, counter = 0, cpu_mem_ready = 0, cpu_mem_rdata = 0, dev_mem_valid = 0, bus_err = 0, err_timeout = 0, err_addr = 0.
REQ-026 Reset asserted mid-ACCESS SHALL drop dev_mem_valid immediately with no response generated after release.

Structure
REQ-027 FSM state encodings and the default ERR_RDATA value SHALL live in shared package bus_pkg.
REQ-028 The wait counter SHALL be sub-module bus_timeout_ctr (parameter TIMEOUT; ports clk, nrst, clr, en, expired).

Verification
REQ-029 Read 0x00000010, BRAM model ready 2 cycles after valid, rdata 0x12345678 -> cpu_mem_ready 1 cycle later with rdata 0x12345678; dev_mem_valid = 2'b01.
REQ-030 Write 0x40000000 wstrb 4'hF, LED model ready immediately -> dev_mem_valid = 2'b10 for 1 cycle; cpu_mem_ready the next cycle.
REQ-031 Read 0x80000000 (unmapped) -> cpu_mem_ready within 2 cycles with rdata 0xDEADBEEF; bus_err = 1, err_timeout = 0, err_addr = 0x80000000.
REQ-032 TIMEOUT = 4, device never ready -> ERR after 4 ACCESS cycles; err_timeout = 1; a second error leaves err_addr unchanged; err_clr -> all error outputs 0.
REQ-033 Abort: cpu_mem_valid dropped in the 2nd ACCESS cycle -> no cpu_mem_ready pulse; dev_mem_valid = 0 the next cycle.
REQ-034 nrst pulsed low mid-ACCESS -> all outputs 0 asynchronously; the next transaction after release completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-device memory bus interconnect:
// FSM state encodings, default error read data and the address decode helper.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } bus_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating wait counter for an outstanding device access; expired flags the
// cycle in which the count reaches TIMEOUT (never when TIMEOUT is 0).
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires while the increment at the coming edge lands on TIMEOUT.
  assign expired = (TIMEOUT != 32'd0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

endmodule

// File: rtl/mem_bus_interconnect.sv
// Single-master memory bus interconnect: decodes the CPU address onto one of N
// device ports, waits for ready with a timeout, and records sticky bus errors.
module mem_bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned     N         = 2,
  parameter logic [N*32-1:0] DEV_BASE  = {32'h40000000, 32'h00000000},
  parameter logic [N*32-1:0] DEV_MASK  = {32'hFFFFFF00, 32'hFFFF0000},
  parameter int unsigned     TIMEOUT   = 255,
  parameter logic [31:0]     ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            cpu_mem_valid,
  input  logic [31:0]     cpu_mem_addr,
  input  logic [3:0]      cpu_mem_wstrb,
  output logic            cpu_mem_ready,
  output logic [31:0]     cpu_mem_rdata,
  output logic [N-1:0]    dev_mem_valid,
  input  logic [N-1:0]    dev_mem_ready,
  input  logic [N*32-1:0] dev_mem_rdata,
  input  logic            err_clr,
  output logic            bus_err,
  output logic            err_timeout,
  output logic [31:0]     err_addr
);

  localparam int unsigned SW = (N > 32'd1) ? $clog2(N) : 1;

  bus_state_e     state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           cpu_mem_ready_q, cpu_mem_ready_d;
  logic [31:0]    cpu_mem_rdata_q, cpu_mem_rdata_d;
  logic [N-1:0]   dev_mem_valid_q, dev_mem_valid_d;
  logic           bus_err_q, bus_err_d;
  logic           err_timeout_q, err_timeout_d;
  logic [31:0]    err_addr_q, err_addr_d;

  logic           hit_s;
  logic [SW-1:0]  hit_idx_s;
  logic           dev_ready_sel_s;
  logic           expired_s;
  logic           err_enter_s;
  logic           unused_s;

  // Write strobes reach the devices on the shared CPU bus, not through here.
  assign unused_s = ^cpu_mem_wstrb;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (addr_match(cpu_mem_addr, DEV_BASE[32*i +: 32], DEV_MASK[32*i +: 32])) begin
        hit_s     = 1'b1;
        hit_idx_s = SW'(i);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  assign dev_ready_sel_s = dev_mem_ready[sel_q];

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (state_q == ST_IDLE),
    .en      ((state_q == ST_ACCESS) && !dev_ready_sel_s),
    .expired (expired_s)
  );

  // Transaction FSM: next state, response pulse and read data capture.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    cpu_mem_ready_d = 1'b0;
    cpu_mem_rdata_d = cpu_mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_mem_valid && hit_s) begin
          sel_d   = hit_idx_s;
          state_d = ST_ACCESS;
        end else if (cpu_mem_valid) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!cpu_mem_valid) begin
          state_d = ST_IDLE;
        end else if (dev_ready_sel_s) begin
          state_d         = ST_DONE;
          cpu_mem_ready_d = 1'b1;
          cpu_mem_rdata_d = dev_mem_rdata[32*sel_q +: 32];
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ERR) begin
      cpu_mem_ready_d = 1'b1;
      cpu_mem_rdata_d = ERR_RDATA;
    end else begin
      cpu_mem_ready_d = cpu_mem_ready_d;
    end
    for (int i = 0; i < int'(N); i++) begin
      dev_mem_valid_d[i] = (state_d == ST_ACCESS) && (sel_d == SW'(i));
    end
  end

  // Sticky error capture; a new error entry overrides a same-cycle clear.
  always_comb begin
    err_enter_s   = (state_d == ST_ERR);
    bus_err_d     = bus_err_q;
    err_timeout_d = err_timeout_q;
    err_addr_d    = err_addr_q;
    if (err_enter_s && (!bus_err_q || err_clr)) begin
      bus_err_d     = 1'b1;
      err_timeout_d = (state_q == ST_ACCESS);
      err_addr_d    = cpu_mem_addr;
    end else if (err_clr) begin
      bus_err_d     = 1'b0;
      err_timeout_d = 1'b0;
      err_addr_d    = 32'h0000_0000;
    end else begin
      bus_err_d     = bus_err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= ST_IDLE;
      sel_q           <= '0;
      cpu_mem_ready_q <= 1'b0;
      cpu_mem_rdata_q <= 32'h0000_0000;
      dev_mem_valid_q <= '0;
      bus_err_q       <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_addr_q      <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      cpu_mem_ready_q <= cpu_mem_ready_d;
      cpu_mem_rdata_q <= cpu_mem_rdata_d;
      dev_mem_valid_q <= dev_mem_valid_d;
      bus_err_q       <= bus_err_d;
      err_timeout_q   <= err_timeout_d;
      err_addr_q      <= err_addr_d;
    end
  end

  assign cpu_mem_ready = cpu_mem_ready_q;
  assign cpu_mem_rdata = cpu_mem_rdata_q;
  assign dev_mem_valid = dev_mem_valid_q;
  assign bus_err       = bus_err_q;
  assign err_timeout   = err_timeout_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// Directed bench for mem_bus_interconnect (TIMEOUT = 4): a table of single
// transactions plus hand-written reset, abort, timeout and error-clear sequences.
module tb_mem_bus_interconnect;

  logic        clk;
  logic        nrst;
  logic        cpu_mem_valid;
  logic [31:0] cpu_mem_addr;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic [1:0]  dev_mem_valid;
  logic [1:0]  dev_mem_ready;
  logic [63:0] dev_mem_rdata;
  logic        err_clr;
  logic        bus_err;
  logic        err_timeout;
  logic [31:0] err_addr;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_interconnect #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .cpu_mem_valid (cpu_mem_valid),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_wstrb (cpu_mem_wstrb),
    .cpu_mem_ready (cpu_mem_ready),
    .cpu_mem_rdata (cpu_mem_rdata),
    .dev_mem_valid (dev_mem_valid),
    .dev_mem_ready (dev_mem_ready),
    .dev_mem_rdata (dev_mem_rdata),
    .err_clr       (err_clr),
    .bus_err       (bus_err),
    .err_timeout   (err_timeout),
    .err_addr      (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    int          delay;     // cycles of valid before ready; -1 = never ready
    logic [31:0] drd;
    int          exp_lat;   // cycles from valid to cpu_mem_ready seen
    logic [31:0] exp_rdata;
    logic [1:0]  exp_vseen;
    int          exp_vcyc;
    logic        exp_berr;
    logic        exp_eto;
    logic [31:0] exp_eaddr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one CPU access and plays the device side until cpu_mem_ready.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                         input int delay, input logic [31:0] drd,
                         output int lat, output logic [31:0] rd,
                         output logic [1:0] vseen, output int vcyc);
    int c;
    bit done;
    lat = 0; rd = 32'h0; vseen = 2'b00; vcyc = 0; done = 1'b0; c = 0;
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = addr;
    cpu_mem_wstrb = wstrb;
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
      dev_mem_ready = 2'b00;
      if (cpu_mem_ready) begin
        lat  = c;
        rd   = cpu_mem_rdata;
        done = 1'b1;
      end else if (dev_mem_valid != 2'b00) begin
        vcyc++;
        vseen = vseen | dev_mem_valid;
        for (int i = 0; i < 2; i++) dev_mem_rdata[32*i +: 32] = dev_mem_valid[i] ? drd : ~drd;
        if (delay >= 0 && vcyc == delay + 1) dev_mem_ready = dev_mem_valid;
      end
    end
    cpu_mem_valid = 1'b0;
    dev_mem_ready = 2'b00;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL txn_timeout: no cpu_mem_ready within 40 cycles for addr %h", addr);
    end
  endtask

  task automatic chk_err(input string tag, input logic be, input logic eto, input logic [31:0] ea);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'(be));
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(eto));
    chk({tag, "_err_addr"}, err_addr, ea);
  endtask

  initial begin
    int lat;
    int vcyc;
    logic [31:0] rd;
    logic [1:0]  vseen;

    //          addr           wstrb delay drd           lat rdata         vseen vcyc be   eto  eaddr
    vecs[0] = '{32'h0000_0010, 4'h0,  2, 32'h1234_5678, 4, 32'h1234_5678, 2'b01, 3, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h4000_0000, 4'hF,  0, 32'h0000_0000, 2, 32'h0000_0000, 2'b10, 1, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{32'h4000_00FC, 4'h0,  1, 32'hA5A5_0001, 3, 32'hA5A5_0001, 2'b10, 2, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_FFFC, 4'h3,  0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 2'b01, 1, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{32'h4000_0100, 4'h0,  0, 32'h1111_1111, 1, 32'hDEAD_BEEF, 2'b00, 0, 1'b1, 1'b0, 32'h4000_0100};
    vecs[5] = '{32'h0001_0000, 4'h0,  0, 32'h2222_2222, 1, 32'hDEAD_BEEF, 2'b00, 0, 1'b1, 1'b0, 32'h4000_0100};
    vecs[6] = '{32'h0000_0010, 4'h0,  3, 32'h0BAD_CAFE, 5, 32'h0BAD_CAFE, 2'b01, 4, 1'b1, 1'b0, 32'h4000_0100};
    vecs[7] = '{32'h0000_0020, 4'h0, -1, 32'h3333_3333, 5, 32'hDEAD_BEEF, 2'b01, 4, 1'b1, 1'b0, 32'h4000_0100};

    nrst = 1'b0; cpu_mem_valid = 1'b0; cpu_mem_addr = 32'h0; cpu_mem_wstrb = 4'h0;
    dev_mem_ready = 2'b00; dev_mem_rdata = 64'h0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 32'(cpu_mem_ready), 32'h0);
    chk("rst_cpu_rdata", cpu_mem_rdata, 32'h0);
    chk("rst_dev_valid", 32'(dev_mem_valid), 32'h0);
    chk_err("rst", 1'b0, 1'b0, 32'h0);
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].addr, vecs[v].wstrb, vecs[v].delay, vecs[v].drd, lat, rd, vseen, vcyc);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
      chk($sformatf("v%0d_dev_valid", v), 32'(vseen), 32'(vecs[v].exp_vseen));
      chk($sformatf("v%0d_valid_cycles", v), 32'(vcyc), 32'(vecs[v].exp_vcyc));
      chk_err($sformatf("v%0d", v), vecs[v].exp_berr, vecs[v].exp_eto, vecs[v].exp_eaddr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_one_cycle", v), 32'(cpu_mem_ready), 32'h0);
      chk($sformatf("v%0d_idle_dev_valid", v), 32'(dev_mem_valid), 32'h0);
    end

    // Reset in the middle of an access, with error flags and rdata non-zero.
    cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h4000_0000;
    @(posedge clk); #1;
    chk("rstmid_pre_valid", 32'(dev_mem_valid), 32'h2);
    #3;
    nrst = 1'b0; cpu_mem_valid = 1'b0;
    #1;
    chk("rstmid_dev_valid", 32'(dev_mem_valid), 32'h0);
    chk("rstmid_cpu_ready", 32'(cpu_mem_ready), 32'h0);
    chk("rstmid_cpu_rdata", cpu_mem_rdata, 32'h0);
    chk_err("rstmid", 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rstmid_post%0d_quiet", k), {30'h0, cpu_mem_ready, |dev_mem_valid}, 32'h0);
    end
    run_txn(32'h0000_0010, 4'h0, 2, 32'h1234_5678, lat, rd, vseen, vcyc);
    chk("rstmid_next_latency", 32'(lat), 32'd4);
    chk("rstmid_next_rdata", rd, 32'h1234_5678);
    @(posedge clk); #1;

    // Timeout as the first recorded error.
    run_txn(32'h0000_0020, 4'h0, -1, 32'h4444_4444, lat, rd, vseen, vcyc);
    chk("to_latency", 32'(lat), 32'd5);
    chk("to_valid_cycles", 32'(vcyc), 32'd4);
    chk("to_rdata", rd, 32'hDEAD_BEEF);
    chk_err("to", 1'b1, 1'b1, 32'h0000_0020);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk_err("clr", 1'b0, 1'b0, 32'h0);

    // Unmapped error, then a second error coinciding with err_clr.
    run_txn(32'h8000_0000, 4'h0, 0, 32'h0, lat, rd, vseen, vcyc);
    chk("unm_latency", 32'(lat), 32'd1);
    chk("unm_rdata", rd, 32'hDEAD_BEEF);
    chk_err("unm", 1'b1, 1'b0, 32'h8000_0000);
    @(posedge clk); #1;
    err_clr = 1'b1;
    run_txn(32'h9000_0000, 4'h0, 0, 32'h0, lat, rd, vseen, vcyc);
    err_clr = 1'b0;
    chk_err("clr_vs_err", 1'b1, 1'b0, 32'h9000_0000);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr2_bus_err", 32'(bus_err), 32'h0);

    // Abort: valid dropped during the second ACCESS cycle.
    cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h0000_0010;
    @(posedge clk); #1;
    chk("abort_valid1", 32'(dev_mem_valid), 32'h1);
    @(posedge clk); #1;
    chk("abort_valid2", 32'(dev_mem_valid), 32'h1);
    cpu_mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_dev_valid", 32'(dev_mem_valid), 32'h0);
    chk("abort_ready_a", 32'(cpu_mem_ready), 32'h0);
    @(posedge clk); #1;
    chk("abort_ready_b", 32'(cpu_mem_ready), 32'h0);
    chk("abort_bus_err", 32'(bus_err), 32'h0);

    // Back-to-back: second request raised while the first is in DONE.
    run_txn(32'h4000_0004, 4'hF, 0, 32'h5555_0000, lat, rd, vseen, vcyc);
    chk("b2b_first_latency", 32'(lat), 32'd2);
    run_txn(32'h0000_0008, 4'h0, 0, 32'h6666_0000, lat, rd, vseen, vcyc);
    chk("b2b_second_latency", 32'(lat), 32'd3);
    chk("b2b_second_rdata", rd, 32'h6666_0000);
    chk("b2b_second_valid", 32'(vseen), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
